// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter request arbiter: FSM state encoding,
// direction codes and a width helper for pointer/hold counters.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Bits needed to encode values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector. The pending vector is rotated so the
// slot just after ptr lands at position 0, then the lowest set rotated bit wins.
module rr_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             any_valid
);

  logic [N_REQ-1:0] rotated;
  logic [PTR_W-1:0] slot_idx [N_REQ];

  // Requester index examined k+1 places after ptr, modulo N_REQ.
  function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + 1 + k;
    if (s >= N_REQ) begin
      s = s - N_REQ;
    end else begin
      s = s;
    end
    return s[PTR_W-1:0];
  endfunction

  // Rotate pending so search order starts just after the last winner.
  always_comb begin
    rotated = '0;
    for (int k = 0; k < N_REQ; k++) begin
      slot_idx[k] = slot_of(ptr, k);
      rotated[k]  = pending[slot_idx[k]];
    end
  end

  // Priority-encode the rotated vector; lowest rotated position wins.
  always_comb begin
    winner    = '0;
    any_valid = |rotated;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      winner = rotated[k] ? slot_idx[k] : winner;
    end
  end

endmodule

// File: rtl/counter_req_arbiter.sv
// One shared up/down counter serving N_REQ latched inc/dec requests in
// round-robin order, one update per slot, with a hold-off gap after each update.
module counter_req_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int SATURATE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] dir,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] overrun,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             at_max,
  output logic             at_min
);

  localparam int PTR_W  = clog2(N_REQ);
  localparam int HOLD_W = clog2(HOLD_CYCLES + 1);
  localparam logic [PTR_W-1:0]  PTR_RST   = PTR_W'(N_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;
  localparam logic [WIDTH-1:0]  CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  CNT_MIN   = '0;
  localparam logic [WIDTH-1:0]  CNT_ONE   = WIDTH'(1);

  state_t             state;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr;
  logic [N_REQ-1:0]   pending;
  logic [N_REQ-1:0]   pend_dir;
  logic [HOLD_W-1:0]  hold_cnt;

  logic [N_REQ-1:0]   clr_mask;
  logic [N_REQ-1:0]   drop;
  logic [N_REQ-1:0]   accept;
  logic [N_REQ-1:0]   pending_nxt;
  logic [N_REQ-1:0]   pend_dir_nxt;
  logic [N_REQ-1:0]   grant_nxt;
  logic               win_dir;
  logic [WIDTH-1:0]   cnt_nxt;
  logic [PTR_W-1:0]   arb_winner;
  logic               arb_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .pending   (pending),
    .ptr       (ptr),
    .winner    (arb_winner),
    .any_valid (arb_valid)
  );

  // Pending bit that retires at the end of the current APPLY cycle.
  always_comb begin
    clr_mask = '0;
    if (state == ST_APPLY) begin
      clr_mask[win_idx] = 1'b1;
    end else begin
      clr_mask = '0;
    end
  end

  // Request capture: new req sets pending (and beats the retiring clear);
  // a req on an already-pending, non-retiring slot is dropped as an overrun.
  always_comb begin
    drop         = req & pending & ~clr_mask;
    accept       = req & ~drop;
    pending_nxt  = (pending & ~clr_mask) | req;
    pend_dir_nxt = (pend_dir & ~accept) | (dir & accept);
  end

  // Next counter value for the latched winner, wrapping or clamping.
  always_comb begin
    win_dir = pend_dir[win_idx];
    cnt_nxt = count;
    if (win_dir == DIR_UP) begin
      if ((SATURATE != 0) && (count == CNT_MAX)) begin
        cnt_nxt = count;
      end else begin
        cnt_nxt = count + CNT_ONE;
      end
    end else begin
      if ((SATURATE != 0) && (count == CNT_MIN)) begin
        cnt_nxt = count;
      end else begin
        cnt_nxt = count - CNT_ONE;
      end
    end
  end

  // One-hot form of the arbiter's current choice.
  always_comb begin
    grant_nxt             = '0;
    grant_nxt[arb_winner] = 1'b1;
  end

  // Control FSM with request registers, hold counter and counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      win_idx  <= '0;
      ptr      <= PTR_RST;
      pending  <= '0;
      pend_dir <= {N_REQ{DIR_DN}};
      hold_cnt <= '0;
      count    <= '0;
      grant    <= '0;
      overrun  <= '0;
      busy     <= 1'b0;
    end else if (clear) begin
      state    <= ST_IDLE;
      win_idx  <= '0;
      ptr      <= PTR_RST;
      pending  <= '0;
      pend_dir <= {N_REQ{DIR_DN}};
      hold_cnt <= '0;
      count    <= '0;
      grant    <= '0;
      overrun  <= '0;
      busy     <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      pend_dir <= pend_dir_nxt;
      overrun  <= drop;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            win_idx <= arb_winner;
            grant   <= grant_nxt;
            busy    <= 1'b1;
            state   <= ST_APPLY;
          end else begin
            grant   <= '0;
            busy    <= 1'b0;
          end
        end
        ST_APPLY: begin
          count <= cnt_nxt;
          ptr   <= win_idx;
          grant <= '0;
          if (HOLD_CYCLES > 0) begin
            hold_cnt <= HOLD_LOAD;
            busy     <= 1'b1;
            state    <= ST_HOLD;
          end else begin
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          grant <= '0;
          if (hold_cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign at_max = (count == CNT_MAX);
  assign at_min = (count == CNT_MIN);

endmodule

// File: tb/tb_counter_req_arbiter.sv
// Directed bench: a wrapping DUT and a saturating DUT share all inputs.
// A cycle table covers arbitration order and overrun; short sequences cover
// wrap/saturate limits, clear during APPLY and reset during HOLD.
module tb_counter_req_arbiter;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [3:0] req;
  logic [3:0] dir;

  logic [3:0] grant, overrun, count;
  logic       busy, at_max, at_min;
  logic [3:0] grant_s, overrun_s, count_s;
  logic       busy_s, at_max_s, at_min_s;

  int checks;
  int failures;

  counter_req_arbiter #(.N_REQ(4), .WIDTH(4), .HOLD_CYCLES(2), .SATURATE(0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .req(req), .dir(dir),
    .grant(grant), .overrun(overrun), .count(count), .busy(busy),
    .at_max(at_max), .at_min(at_min)
  );

  counter_req_arbiter #(.N_REQ(4), .WIDTH(4), .HOLD_CYCLES(2), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .req(req), .dir(dir),
    .grant(grant_s), .overrun(overrun_s), .count(count_s), .busy(busy_s),
    .at_max(at_max_s), .at_min(at_min_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] dir;
    logic [3:0] grant;
    logic [3:0] count;
    logic       busy;
    logic [3:0] ovr;
  } vec_t;

  vec_t vecs [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse one request from idle and follow it through grant, update and hold.
  task automatic serve_one(input int idx, input logic d, input logic [3:0] ew,
                           input logic [3:0] es, input string nm);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    req = 4'b0000;
    dir = 4'b0000;
    req[idx] = 1'b1;
    dir[idx] = d;
    tick();
    req = 4'b0000;
    dir = 4'b0000;
    chk({nm, "_c1_grant"}, grant, 4'b0000);
    tick();
    chk({nm, "_c2_grant"}, grant, oh);
    chk({nm, "_c2_grant_sat"}, grant_s, oh);
    tick();
    chk({nm, "_c3_count"}, count, ew);
    chk({nm, "_c3_count_sat"}, count_s, es);
    tick();
    tick();
    chk({nm, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    clear    = 1'b0;
    req      = 4'b0000;
    dir      = 4'b0000;

    // Arbitration order, spacing and count sequence for req=1111 dir=0101
    vecs[0]  = '{4'b1111, 4'b0101, 4'b0000, 4'h0, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0000, 4'b0000, 4'b0001, 4'h0, 1'b1, 4'b0000};
    vecs[2]  = '{4'b0000, 4'b0000, 4'b0000, 4'h1, 1'b1, 4'b0000};
    vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 4'h1, 1'b1, 4'b0000};
    vecs[4]  = '{4'b0000, 4'b0000, 4'b0000, 4'h1, 1'b0, 4'b0000};
    vecs[5]  = '{4'b0000, 4'b0000, 4'b0010, 4'h1, 1'b1, 4'b0000};
    vecs[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'h0, 1'b1, 4'b0000};
    vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'h0, 1'b1, 4'b0000};
    vecs[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'h0, 1'b0, 4'b0000};
    vecs[9]  = '{4'b0000, 4'b0000, 4'b0100, 4'h0, 1'b1, 4'b0000};
    vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 4'h1, 1'b1, 4'b0000};
    vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 4'h1, 1'b1, 4'b0000};
    vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 4'h1, 1'b0, 4'b0000};
    vecs[13] = '{4'b0000, 4'b0000, 4'b1000, 4'h1, 1'b1, 4'b0000};
    vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 4'h0, 1'b1, 4'b0000};
    vecs[15] = '{4'b0000, 4'b0000, 4'b0000, 4'h0, 1'b1, 4'b0000};
    vecs[16] = '{4'b0000, 4'b0000, 4'b0000, 4'h0, 1'b0, 4'b0000};
    // Overrun on a pending requester, then a req coincident with its grant
    vecs[17] = '{4'b0100, 4'b0100, 4'b0000, 4'h0, 1'b0, 4'b0000};
    vecs[18] = '{4'b0100, 4'b0100, 4'b0100, 4'h0, 1'b1, 4'b0100};
    vecs[19] = '{4'b0000, 4'b0000, 4'b0000, 4'h1, 1'b1, 4'b0000};
    vecs[20] = '{4'b0000, 4'b0000, 4'b0000, 4'h1, 1'b1, 4'b0000};
    vecs[21] = '{4'b0000, 4'b0000, 4'b0000, 4'h1, 1'b0, 4'b0000};
    vecs[22] = '{4'b0000, 4'b0000, 4'b0000, 4'h1, 1'b0, 4'b0000};
    vecs[23] = '{4'b0100, 4'b0000, 4'b0000, 4'h1, 1'b0, 4'b0000};
    vecs[24] = '{4'b0000, 4'b0000, 4'b0100, 4'h1, 1'b1, 4'b0000};
    vecs[25] = '{4'b0100, 4'b0100, 4'b0000, 4'h0, 1'b1, 4'b0000};
    vecs[26] = '{4'b0000, 4'b0000, 4'b0000, 4'h0, 1'b1, 4'b0000};
    vecs[27] = '{4'b0000, 4'b0000, 4'b0000, 4'h0, 1'b0, 4'b0000};
    vecs[28] = '{4'b0000, 4'b0000, 4'b0100, 4'h0, 1'b1, 4'b0000};
    vecs[29] = '{4'b0000, 4'b0000, 4'b0000, 4'h1, 1'b1, 4'b0000};
    vecs[30] = '{4'b0000, 4'b0000, 4'b0000, 4'h1, 1'b1, 4'b0000};
    vecs[31] = '{4'b0000, 4'b0000, 4'b0000, 4'h1, 1'b0, 4'b0000};

    // Reset state
    tick();
    tick();
    chk("rst_count", count, 4'h0);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 4'b0000);
    chk("rst_at_min", at_min, 1'b1);
    chk("rst_at_max", at_max, 1'b0);
    reset = 1'b1;
    tick();
    chk("rst_rel_busy", busy, 1'b0);
    chk("rst_rel_count_sat", count_s, 4'h0);

    // Table-driven cycles
    for (int i = 0; i < 32; i++) begin
      req = vecs[i].req;
      dir = vecs[i].dir;
      tick();
      chk($sformatf("vec%0d_grant", i), grant, vecs[i].grant);
      chk($sformatf("vec%0d_count", i), count, vecs[i].count);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_overrun", i), overrun, vecs[i].ovr);
    end
    req = 4'b0000;
    dir = 4'b0000;

    // Wrap and saturate limits
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_count", count, 4'h0);
    chk("clear_count_sat", count_s, 4'h0);
    serve_one(0, 1'b0, 4'hF, 4'h0, "wrap_dec");
    chk("wrap_dec_at_max", at_max, 1'b1);
    chk("sat_dec_at_min", at_min_s, 1'b1);
    serve_one(0, 1'b1, 4'h0, 4'h1, "wrap_inc");
    chk("wrap_inc_at_min", at_min, 1'b1);
    for (int i = 0; i < 14; i++) begin
      serve_one(0, 1'b1, 4'(i + 1), 4'(i + 2), $sformatf("ramp%0d", i));
    end
    serve_one(0, 1'b1, 4'hF, 4'hF, "sat_at_max_inc");
    serve_one(0, 1'b1, 4'h0, 4'hF, "wrap_max_inc");
    chk("wrap_max_at_min", at_min, 1'b1);
    chk("sat_max_at_max", at_max_s, 1'b1);

    // Clear during APPLY with pending=0110
    req = 4'b0110;
    dir = 4'b0110;
    tick();
    req = 4'b0000;
    dir = 4'b0000;
    tick();
    chk("clr_apply_grant", grant, 4'b0010);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_count", count, 4'h0);
    chk("clr_count_sat", count_s, 4'h0);
    chk("clr_grant", grant, 4'b0000);
    chk("clr_busy", busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("clr_quiet%0d_grant", i), grant, 4'b0000);
      chk($sformatf("clr_quiet%0d_grant_sat", i), grant_s, 4'b0000);
    end
    serve_one(3, 1'b1, 4'h1, 4'h1, "after_clear");

    // Reset asserted mid-HOLD with count=5
    serve_one(1, 1'b1, 4'h2, 4'h2, "up2");
    serve_one(1, 1'b1, 4'h3, 4'h3, "up3");
    serve_one(1, 1'b1, 4'h4, 4'h4, "up4");
    req = 4'b0010;
    dir = 4'b0010;
    tick();
    req = 4'b0000;
    dir = 4'b0000;
    tick();
    tick();
    chk("hold_count5", count, 4'h5);
    chk("hold_busy", busy, 1'b1);
    reset = 1'b0;
    #2;
    chk("rst_hold_count", count, 4'h0);
    chk("rst_hold_busy", busy, 1'b0);
    chk("rst_hold_grant", grant, 4'b0000);
    tick();
    chk("rst_hold_next_count", count, 4'h0);
    chk("rst_hold_next_busy_sat", busy_s, 1'b0);
    reset = 1'b1;
    tick();
    chk("rst_hold_rel_busy", busy, 1'b0);
    serve_one(2, 1'b1, 4'h1, 4'h1, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
